// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_arbiter
// Purpose  : Packet-level round-robin arbiter sharing one AXI-Stream master
//            port between NUM_IN AXI-Stream slave ports. A grant is decided
//            in IDLE and then held for the whole packet, until the tlast beat
//            is accepted. Payload passes combinationally under the registered
//            grant; a wrapping 16-bit completed-packet counter is kept.
// Ports    : aclk, areset        - clock, synchronous active-high reset
//            s_tvalid/s_tready/s_tlast [NUM_IN] - per-input handshake
//            s_tdata [NUM_IN*DATA_W] - input i at [i*DATA_W +: DATA_W]
//            m_tvalid/m_tready/m_tlast/m_tdata  - shared output stream
//            m_tid   - index of the granted input
//            busy    - high while a packet is in progress
//            pkt_cnt - packets completed on the output (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 64,
    parameter int ID_W   = $clog2(NUM_IN)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [NUM_IN-1:0]        s_tvalid,
    output logic [NUM_IN-1:0]        s_tready,
    input  logic [NUM_IN-1:0]        s_tlast,
    input  logic [NUM_IN*DATA_W-1:0] s_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic [DATA_W-1:0]        m_tdata,
    output logic [ID_W-1:0]          m_tid,
    output logic                     busy,
    output logic [15:0]              pkt_cnt
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [ID_W-1:0] r_grant;
    logic [ID_W-1:0] w_grant_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_rr_nxt;
    logic [15:0]     r_pkt_cnt;
    logic [15:0]     w_cnt_nxt;

    logic              w_busy;
    logic              w_accept;
    logic              w_arb_found;
    logic [ID_W-1:0]   w_arb_idx;
    logic [ID_W:0]     w_probe;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [DATA_W-1:0] w_sel_data;
    logic [NUM_IN-1:0] w_ready_vec;

    // Round-robin search: probe rr_ptr, rr_ptr+1, ... with wrap at NUM_IN.
    // One extra bit on the probe lets the wrap be done by a compare/subtract,
    // which also covers NUM_IN values that are not a power of two.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_probe     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_probe = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_probe >= (ID_W+1)'(NUM_IN)) begin
                w_probe = w_probe - (ID_W+1)'(NUM_IN);
            end
            if (!w_arb_found && s_tvalid[w_probe[ID_W-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_probe[ID_W-1:0];
            end
        end
    end

    // Grant multiplexer over the flattened inputs.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_ready_vec = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (r_grant == ID_W'(i)) begin
                w_sel_valid    = s_tvalid[i];
                w_sel_last     = s_tlast[i];
                w_sel_data     = s_tdata[i*DATA_W +: DATA_W];
                w_ready_vec[i] = 1'b1;
            end
        end
    end

    // Outputs are gated by BUSY so IDLE (and reset) presents all zeros.
    assign w_busy   = (r_state == c_st_busy);
    assign m_tvalid = w_busy & w_sel_valid;
    assign m_tlast  = w_busy & w_sel_last;
    assign m_tdata  = w_busy ? w_sel_data : '0;
    assign s_tready = (w_busy && m_tready) ? w_ready_vec : '0;
    assign m_tid    = r_grant;
    assign busy     = w_busy;
    assign pkt_cnt  = r_pkt_cnt;
    assign w_accept = m_tvalid & m_tready;

    // Next-state: arbitrate in IDLE, release the grant on the accepted tlast.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_pkt_cnt;
        if (r_state == c_st_idle) begin
            if (w_arb_found) begin
                w_grant_nxt = w_arb_idx;
                w_state_nxt = c_st_busy;
            end
        end else begin
            if (w_accept && m_tlast) begin
                w_state_nxt = c_st_idle;
                w_rr_nxt    = (r_grant == ID_W'(NUM_IN-1)) ? '0 : r_grant + ID_W'(1);
                w_cnt_nxt   = r_pkt_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= c_st_idle;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_pkt_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_pkt_cnt <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_arbiter
// Purpose  : Directed self-checking bench for axis_pkt_arbiter (NUM_IN=4,
//            DATA_W=64). Inputs change 1 time unit after each rising edge;
//            outputs are checked 1 unit later, well away from the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_arbiter;

    localparam int NUM_IN = 4;
    localparam int DATA_W = 64;
    localparam int ID_W   = 2;

    logic                     aclk = 1'b0;
    logic                     areset;
    logic [NUM_IN-1:0]        s_tvalid;
    logic [NUM_IN-1:0]        s_tready;
    logic [NUM_IN-1:0]        s_tlast;
    logic [NUM_IN*DATA_W-1:0] s_tdata;
    logic                     m_tvalid;
    logic                     m_tready;
    logic                     m_tlast;
    logic [DATA_W-1:0]        m_tdata;
    logic [ID_W-1:0]          m_tid;
    logic                     busy;
    logic [15:0]              pkt_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    axis_pkt_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .s_tdata  (s_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .m_tdata  (m_tdata),
        .m_tid    (m_tid),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic l, input logic [63:0] d);
        s_tvalid[i]             = v;
        s_tlast[i]              = l;
        s_tdata[i*DATA_W +: 64] = d;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_tready"}, 64'(s_tready), 64'h0);
        chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'h0);
        chk({tag, "_m_tlast"},  64'(m_tlast),  64'h0);
        chk({tag, "_m_tid"},    64'(m_tid),    64'h0);
        chk({tag, "_busy"},     64'(busy),     64'h0);
        chk({tag, "_pkt_cnt"},  64'(pkt_cnt),  64'h0);
        chk({tag, "_m_tdata"},  m_tdata,       64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] b;
        logic [3:0] rdy;
        int         k;
        logic       tr;

        areset   = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        tick;
        tick;
        chk_reset_outputs("rst");
        areset = 1'b0;

        // ---- single-source packet from input 2 ----
        drive(2, 1'b1, 1'b0, 64'hA0);
        m_tready = 1'b1;
        #1;
        chk("s1_arb_bubble", 64'(m_tvalid), 64'h0);
        chk("s1_arb_busy",   64'(busy),     64'h0);
        tick;
        #1;
        chk("s1_tid",     64'(m_tid),    64'h2);
        chk("s1_b0_vld",  64'(m_tvalid), 64'h1);
        chk("s1_b0_data", m_tdata,       64'hA0);
        chk("s1_b0_rdy",  64'(s_tready), 64'h4);
        tick;
        drive(2, 1'b1, 1'b0, 64'hA1);
        #1;
        chk("s1_b1_vld",  64'(m_tvalid), 64'h1);
        chk("s1_b1_data", m_tdata,       64'hA1);
        tick;
        drive(2, 1'b1, 1'b1, 64'hA2);
        #1;
        chk("s1_b2_vld",  64'(m_tvalid), 64'h1);
        chk("s1_b2_data", m_tdata,       64'hA2);
        chk("s1_b2_last", 64'(m_tlast),  64'h1);
        tick;
        drive(2, 1'b0, 1'b0, 64'h0);
        #1;
        chk("s1_end_busy", 64'(busy),     64'h0);
        chk("s1_end_vld",  64'(m_tvalid), 64'h0);
        chk("s1_pkt_cnt",  64'(pkt_cnt),  64'h1);

        // ---- pointer at 3, inputs 1 and 3 request; counter wraps ----
        force dut.r_pkt_cnt = 16'hFFFE;
        #1;
        release dut.r_pkt_cnt;
        drive(1, 1'b1, 1'b1, 64'h11);
        drive(3, 1'b1, 1'b1, 64'h33);
        #1;
        chk("wr_arb_bubble", 64'(m_tvalid), 64'h0);
        tick;
        #1;
        chk("wr_tid3",   64'(m_tid),    64'h3);
        chk("wr_data3",  m_tdata,       64'h33);
        chk("wr_rdy3",   64'(s_tready), 64'h8);
        tick;
        drive(3, 1'b0, 1'b0, 64'h0);
        #1;
        chk("wr_cnt_ffff", 64'(pkt_cnt), 64'hFFFF);
        chk("wr_idle",     64'(busy),    64'h0);
        tick;
        #1;
        chk("wr_tid1",  64'(m_tid), 64'h1);
        chk("wr_data1", m_tdata,    64'h11);
        tick;
        drive(1, 1'b0, 1'b0, 64'h0);
        #1;
        chk("wr_cnt_wrap", 64'(pkt_cnt), 64'h0);

        // ---- round-robin fairness from reset: 2-beat packets on all inputs ----
        areset = 1'b1;
        tick;
        areset = 1'b0;
        b = '0;
        for (int c = 0; c < 18; c++) begin
            int phase;
            int g;
            phase = c % 3;
            g     = (c / 3) % 4;
            for (int i = 0; i < NUM_IN; i++) begin
                drive(i, 1'b1, b[i], 64'(i * 256) | 64'(b[i]));
            end
            #1;
            rdy = s_tready;
            chk("rr_vld", 64'(m_tvalid), (phase != 0) ? 64'h1 : 64'h0);
            chk("rr_rdy", 64'(s_tready), (phase != 0) ? (64'h1 << g) : 64'h0);
            if (phase != 0) begin
                chk("rr_tid",  64'(m_tid),   64'(g));
                chk("rr_data", m_tdata,      64'(g * 256 + phase - 1));
                chk("rr_last", 64'(m_tlast), (phase == 2) ? 64'h1 : 64'h0);
            end
            tick;
            for (int i = 0; i < NUM_IN; i++) begin
                if (rdy[i]) b[i] = ~b[i];
            end
        end
        s_tvalid = '0;
        s_tlast  = '0;
        #1;
        chk("rr_pkt_cnt", 64'(pkt_cnt), 64'h6);

        // ---- backpressure on a 4-beat packet from input 1 ----
        drive(1, 1'b1, 1'b0, 64'hB0);
        m_tready = 1'b1;
        tick;
        k = 0;
        for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
            tr = ((cyc % 3) == 0);
            drive(1, 1'b1, (k == 3), 64'hB0 + 64'(k));
            m_tready = tr;
            #1;
            chk("bp_vld",  64'(m_tvalid), 64'h1);
            chk("bp_data", m_tdata,       64'hB0 + 64'(k));
            chk("bp_rdy",  64'(s_tready), tr ? 64'h2 : 64'h0);
            chk("bp_busy", 64'(busy),     64'h1);
            tick;
            if (tr) k++;
        end
        drive(1, 1'b0, 1'b0, 64'h0);
        m_tready = 1'b1;
        #1;
        chk("bp_end_busy", 64'(busy),    64'h0);
        chk("bp_pkt_cnt",  64'(pkt_cnt), 64'h7);

        // ---- source stall on input 2 while input 0 requests ----
        drive(2, 1'b1, 1'b0, 64'hC0);
        tick;
        #1;
        chk("st_tid",  64'(m_tid), 64'h2);
        chk("st_data", m_tdata,    64'hC0);
        tick;
        drive(2, 1'b0, 1'b0, 64'hC1);
        drive(0, 1'b1, 1'b1, 64'hD0);
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("st_stall_vld",  64'(m_tvalid), 64'h0);
            chk("st_stall_tid",  64'(m_tid),    64'h2);
            chk("st_stall_rdy",  64'(s_tready), 64'h4);
            chk("st_stall_busy", 64'(busy),     64'h1);
            tick;
        end
        drive(2, 1'b1, 1'b1, 64'hC1);
        #1;
        chk("st_resume_vld",  64'(m_tvalid), 64'h1);
        chk("st_resume_data", m_tdata,       64'hC1);
        chk("st_resume_last", 64'(m_tlast),  64'h1);
        tick;
        drive(2, 1'b0, 1'b0, 64'h0);
        #1;
        chk("st_end_busy", 64'(busy),    64'h0);
        chk("st_pkt_cnt",  64'(pkt_cnt), 64'h8);
        tick;
        #1;
        chk("st_next_tid",  64'(m_tid),    64'h0);
        chk("st_next_data", m_tdata,       64'hD0);
        chk("st_next_rdy",  64'(s_tready), 64'h1);
        tick;
        drive(0, 1'b0, 1'b0, 64'h0);
        #1;
        chk("st2_pkt_cnt", 64'(pkt_cnt), 64'h9);

        // ---- reset during beat 2 of a 4-beat packet from input 3 ----
        drive(3, 1'b1, 1'b0, 64'hE0);
        tick;
        #1;
        chk("rm_tid",  64'(m_tid), 64'h3);
        chk("rm_data", m_tdata,    64'hE0);
        tick;
        drive(3, 1'b1, 1'b0, 64'hE1);
        areset = 1'b1;
        #1;
        chk("rm_b2_data", m_tdata, 64'hE1);
        tick;
        areset = 1'b0;
        drive(0, 1'b1, 1'b1, 64'hF0);
        #1;
        chk_reset_outputs("rm");
        tick;
        #1;
        chk("rm_rearb_tid",  64'(m_tid), 64'h0);
        chk("rm_rearb_data", m_tdata,    64'hF0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream master port between NUM_IN AXI-Stream slave ports. It sits in front of a single shared stream consumer, for example a compression engine input. Once an input is granted, the grant holds for the whole packet, until the beat with tlast is accepted. Payload is passed through combinationally under a registered grant, and a packet counter is kept for status.

## Interface
- NUM_IN, 4: number of requesting input streams, 2..8.
- DATA_W, 64: tdata width per stream.
- ID_W, $clog2(NUM_IN): width of grant index / m_tid.
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  reset, synchronous, active-high.
- s_tvalid  in  NUM_IN  per-input tvalid, bit i = input i.
- s_tready  out  NUM_IN  per-input tready.
- s_tlast  in  NUM_IN  per-input tlast.
- s_tdata  in  NUM_IN*DATA_W  flattened; input i at [i*DATA_W +: DATA_W].
- m_tvalid  out  1  output tvalid.
- m_tready  in  1  output tready.
- m_tlast  out  1  output tlast.
- m_tdata  out  DATA_W  output tdata.
- m_tid  out  ID_W  index of the input currently granted.
- busy  out  1  high while a packet is in progress (state BUSY).
- pkt_cnt  out  16  count of packets completed on the output, wraps at 65535 -> 0.

## Operation
- The FSM has two states.
  - IDLE: no grant. All s_tready are 0. m_tvalid = 0.
  - BUSY: input `grant` owns the output.
- Arbitration happens in IDLE when any s_tvalid is 1.
  - Select the first i with s_tvalid[i] = 1, searching from rr_ptr upward with mod-NUM_IN wrap.
  - Register grant = i and go to BUSY on the next edge.
  - No beat transfers in the arbitration cycle.
- Datapath in BUSY:
  - m_tvalid = s_tvalid[grant]; m_tlast = s_tlast[grant]; m_tdata = input grant's slice.
  - s_tready[grant] = m_tready; every other s_tready = 0.
- Beat accepted means BUSY && m_tvalid && m_tready.
- Accepted beat with m_tlast = 1:
  - Go to IDLE.
  - rr_ptr <= (grant+1) mod NUM_IN.
  - pkt_cnt <= pkt_cnt+1.
- A non-last beat keeps BUSY. Any number of beats per packet is allowed; there is no length limit.
- Inputs not granted are ignored. Their tvalid/tdata may change freely, though AXIS rules require them to hold.
- If s_tvalid[grant] drops mid-packet, the grant is kept and m_tvalid = 0 until it returns.
- m_tid = grant in BUSY. In IDLE, m_tid holds the last grant value and is don't-care to consumers.
- Reset mid-packet:
  - Forces IDLE, rr_ptr = 0, grant = 0, pkt_cnt = 0.
  - The in-flight packet is truncated downstream. Recovery is the system's responsibility.

## Timing
- Reset values:
  - s_tready = 0, m_tvalid = 0, m_tlast = 0, m_tid = 0, busy = 0, pkt_cnt = 0.
  - m_tdata is don't-care while m_tvalid = 0, and is 0 in reset.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N gives first beat available at edge N+1.
- Each packet boundary costs one bubble cycle (the IDLE cycle). Peak throughput is L/(L+1) for L-beat packets.
- Within a packet the datapath is zero-latency, with a combinational tvalid/tready/tdata path.
- Simultaneous tlast acceptance and a new request: the new grant is decided in the following IDLE cycle, using the updated rr_ptr.
- pkt_cnt updates on the edge that accepts the tlast beat.

## Test plan
- Single-source packet:
  - Stimulus: input 2 sends 3 beats, tdata 0xA0..0xA2, tlast on 0xA2, m_tready = 1.
  - Required: m_tid = 2; m_tvalid low for exactly 1 cycle, then 3 consecutive beats; pkt_cnt = 1; rr_ptr = 3.
- Round-robin fairness:
  - Stimulus: all 4 inputs continuously offer 2-beat packets from reset.
  - Required: grant order 0,1,2,3,0,1; one bubble between packets; no interleaving of beats.
- Backpressure:
  - Stimulus: input 1 sends a 4-beat packet while m_tready toggles 1,0,0,1,...
  - Required: beats are accepted only when m_tready = 1; m_tdata and s_tready track it; order is preserved; busy stays high throughout.
- Source stall:
  - Stimulus: the granted input drops s_tvalid for 3 cycles mid-packet while input 0 requests.
  - Required: m_tvalid = 0 during the stall; the grant is unchanged; input 0's s_tready stays 0.
- Wrap and pointer skip:
  - Stimulus: rr_ptr = 3, only inputs 1 and 3 requesting.
  - Required: 3 is granted, then 1 (wraps through 0). With pkt_cnt preloaded near 0xFFFF, pkt_cnt wraps 0xFFFF -> 0.
- Reset mid-packet:
  - Stimulus: assert areset for 1 cycle during beat 2 of a 4-beat packet from input 3.
  - Required: the next cycle has all outputs at reset values; the next arbitration starts search at input 0.
